// File: rtl/dpwm_pkg.sv
// Shared definitions for the DPWM duty loader: time-quantity widths,
// minimum on-time, loader FSM encoding and the committed configuration type.
package dpwm_pkg;

  localparam int DPWM_DC_LENGTH = 13;
  localparam int DPWM_DE_BITS   = 6;
  localparam int DPWM_MIN_ON    = 16;

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_CALC      = 2'd1;
  localparam logic [1:0] ST_CLAMP     = 2'd2;
  localparam logic [1:0] ST_WAIT_SYNC = 2'd3;

  typedef enum logic [1:0] {
    IDLE      = ST_IDLE,
    CALC      = ST_CALC,
    CLAMP     = ST_CLAMP,
    WAIT_SYNC = ST_WAIT_SYNC
  } dpwm_state_e;

  typedef struct packed {
    logic [DPWM_DC_LENGTH-1:0] h_on;
    logic [DPWM_DC_LENGTH-1:0] l_on;
    logic [DPWM_DC_LENGTH-1:0] dead_time;
  } dpwm_cfg_t;

endpackage

// File: rtl/dpwm_duty_clamp.sv
// Combinational on-time arithmetic: usable span = period - 2*deadtime,
// high time clamped to [MIN_ON, span-MIN_ON], low time takes the remainder.
// err flags a span too short to fit two minimum pulses.
module dpwm_duty_clamp
  import dpwm_pkg::*;
#(
  parameter int DC_LENGTH = DPWM_DC_LENGTH,
  parameter int MIN_ON    = DPWM_MIN_ON
) (
  input  logic [DC_LENGTH-1:0] duty,
  input  logic [DC_LENGTH-1:0] deadtime,
  input  logic [DC_LENGTH-1:0] period,
  output logic [DC_LENGTH-1:0] h,
  output logic [DC_LENGTH-1:0] l,
  output logic                 clamped,
  output logic                 err
);

  localparam int SW = DC_LENGTH + 2;
  localparam logic signed [SW-1:0] MIN_S     = SW'(MIN_ON);
  localparam logic signed [SW-1:0] TWO_MIN_S = SW'(2 * MIN_ON);

  logic [DC_LENGTH:0]     dt2;
  logic signed [SW-1:0]   span;
  logic signed [SW-1:0]   hi_lim;
  logic signed [SW-1:0]   duty_s;
  logic signed [SW-1:0]   h_s;
  logic signed [SW-1:0]   l_s;

  assign dt2    = {deadtime, 1'b0};
  assign span   = $signed({2'b00, period}) - $signed({1'b0, dt2});
  assign hi_lim = span - MIN_S;
  assign duty_s = $signed({2'b00, duty});
  assign err    = (span < TWO_MIN_S);

  // Clamp the requested high time into the window that leaves MIN_ON for the low side.
  always_comb begin
    h_s     = duty_s;
    clamped = 1'b0;
    if (duty_s < MIN_S) begin
      h_s     = MIN_S;
      clamped = 1'b1;
    end else if (duty_s > hi_lim) begin
      h_s     = hi_lim;
      clamped = 1'b1;
    end
  end

  assign l_s = span - h_s;
  assign h   = DC_LENGTH'(h_s);
  assign l   = DC_LENGTH'(l_s);

endmodule

// File: rtl/dpwm_duty_loader.sv
// DPWM duty loader: accepts duty/deadtime/period commands, computes clamped
// on-times into a shadow and commits them on the DPWM period boundary.
// Optional build macro DUTY_LOADER_FORCE_EN adds force_load, which commits
// a pending shadow exactly like period_sync.
//
// state     | meaning
// IDLE      | no pending shadow, ready for a command
// CALC      | captured command, checking span for rejection
// CLAMP     | writing clamped on-times into the shadow
// WAIT_SYNC | shadow pending, waiting for the period boundary
module dpwm_duty_loader
  import dpwm_pkg::*;
#(
  parameter int DC_LENGTH = DPWM_DC_LENGTH,
  parameter int MIN_ON    = DPWM_MIN_ON
) (
  input  logic                 clk_base,
  input  logic                 rst,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [DC_LENGTH-1:0] cmd_duty,
  input  logic [DC_LENGTH-1:0] cmd_deadtime,
  input  logic [DC_LENGTH-1:0] cmd_period,
  input  logic                 period_sync,
`ifdef DUTY_LOADER_FORCE_EN
  input  logic                 force_load,
`endif
  output logic [DC_LENGTH-1:0] H_on,
  output logic [DC_LENGTH-1:0] L_on,
  output logic [DC_LENGTH-1:0] DeadTime,
  output logic                 cfg_update,
  output logic                 cfg_err,
  output logic                 clamp_flag,
  output logic                 pending
);

  dpwm_state_e          state;
  logic [DC_LENGTH-1:0] cap_duty;
  logic [DC_LENGTH-1:0] cap_dt;
  logic [DC_LENGTH-1:0] cap_period;
  dpwm_cfg_t            shadow;
  dpwm_cfg_t            active;
  logic                 sh_clamped;

  logic [DC_LENGTH-1:0] calc_h;
  logic [DC_LENGTH-1:0] calc_l;
  logic                 calc_clamped;
  logic                 calc_err;
  logic                 accept;
  logic                 commit_req;

`ifdef DUTY_LOADER_FORCE_EN
  assign commit_req = period_sync | force_load;
`else
  assign commit_req = period_sync;
`endif

  assign cmd_ready = (state == IDLE) || (state == WAIT_SYNC);
  assign accept    = cmd_valid & cmd_ready;

  assign H_on     = active.h_on;
  assign L_on     = active.l_on;
  assign DeadTime = active.dead_time;

  dpwm_duty_clamp #(
    .DC_LENGTH (DC_LENGTH),
    .MIN_ON    (MIN_ON)
  ) u_clamp (
    .duty     (cap_duty),
    .deadtime (cap_dt),
    .period   (cap_period),
    .h        (calc_h),
    .l        (calc_l),
    .clamped  (calc_clamped),
    .err      (calc_err)
  );

  // Loader FSM: capture, validate, fill shadow, commit on the period boundary.
  always_ff @(posedge clk_base or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      cap_duty   <= '0;
      cap_dt     <= '0;
      cap_period <= '0;
      shadow     <= '0;
      active     <= '0;
      sh_clamped <= 1'b0;
      clamp_flag <= 1'b0;
      pending    <= 1'b0;
      cfg_update <= 1'b0;
      cfg_err    <= 1'b0;
    end else begin
      cfg_update <= 1'b0;
      cfg_err    <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            cap_duty   <= cmd_duty;
            cap_dt     <= cmd_deadtime;
            cap_period <= cmd_period;
            state      <= CALC;
          end
        end
        CALC: begin
          if (calc_err) begin
            cfg_err <= 1'b1;
            // A rejected command leaves any older shadow in place to commit.
            state   <= pending ? WAIT_SYNC : IDLE;
          end else begin
            state <= CLAMP;
          end
        end
        CLAMP: begin
          shadow.h_on      <= calc_h;
          shadow.l_on      <= calc_l;
          shadow.dead_time <= cap_dt;
          sh_clamped       <= calc_clamped;
          pending          <= 1'b1;
          state            <= WAIT_SYNC;
        end
        WAIT_SYNC: begin
          // Commit the existing shadow first even if a new command lands now.
          if (commit_req) begin
            active     <= shadow;
            clamp_flag <= sh_clamped;
            cfg_update <= 1'b1;
            pending    <= 1'b0;
          end
          if (accept) begin
            cap_duty   <= cmd_duty;
            cap_dt     <= cmd_deadtime;
            cap_period <= cmd_period;
            state      <= CALC;
          end else if (commit_req) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
